mio_bus_responder: RTL



---
 rtl/mio_bus_responder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mio_bus_responder.sv
// MIO bus responder: answers CPU_MIO requests from the SCPU control unit
// with RAM, LED, switch and counter targets after a fixed wait count.
module mio_bus_responder #(
    parameter int WAIT_CYC = 2,
    parameter int RAM_AW   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] addr_bus,
    input  logic [31:0] Cpu_data2bus,
    input  logic [15:0] sw,
    output logic        MIO_ready,
    output logic [31:0] Cpu_data4bus,
    output logic [15:0] led_out,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);
    localparam bit         HAS_WAIT  = (WAIT_CYC > 0);

    state_t state, state_nx;
    logic [3:0]  wcnt, wcnt_nx;
    logic        latch_en;
    logic        lat_w;
    logic [31:0] lat_addr;
    logic [31:0] lat_data;
    logic [31:0] cnt_q;
    logic [31:0] rd_data;
    logic [31:0] ram [0:(1<<RAM_AW)-1];

    logic              is_ack;
    logic              do_wr;
    logic              sel_ram, sel_io, sel_led, sel_sw, sel_cnt;
    logic              unmapped;
    logic [RAM_AW-1:0] ram_idx;
    logic              unused_addr;

    assign is_ack   = (state == S_ACK);
    assign do_wr    = is_ack & lat_w;
    assign sel_ram  = (lat_addr[31:28] == 4'h0);
    assign sel_io   = (lat_addr[31:28] == 4'hF);
    assign sel_cnt  = (lat_addr[31:28] == 4'hE);
    assign sel_led  = sel_io & ~lat_addr[2];
    assign sel_sw   = sel_io & lat_addr[2];
    assign unmapped = ~(sel_ram | sel_io | sel_cnt);
    assign ram_idx  = lat_addr[RAM_AW+1:2];

    // RAM aliases above its index bits and ignores the byte offset
    assign unused_addr = ^{lat_addr[27:RAM_AW+2], lat_addr[1:0]};

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        latch_en = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (CPU_MIO) begin
                    latch_en = 1'b1;
                    wcnt_nx  = WAIT_INIT;
                    state_nx = HAS_WAIT ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                wcnt_nx = wcnt - 4'd1;
                if (wcnt == 4'd1) state_nx = S_ACK;
            end
            S_ACK: state_nx = S_DONE;
            S_DONE: begin
                // a request held high must drop before it is served again
                if (!CPU_MIO) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        rd_data = 32'h0;
        unique case (1'b1)
            sel_ram: rd_data = ram[ram_idx];
            sel_led: rd_data = {16'h0, led_out};
            sel_sw:  rd_data = {16'h0, sw};
            sel_cnt: rd_data = cnt_q;
            default: rd_data = 32'h0;
        endcase
    end

    assign MIO_ready    = is_ack;
    assign Cpu_data4bus = (is_ack && !lat_w) ? rd_data : 32'h0;
    assign bus_err      = is_ack & unmapped;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wcnt     <= 4'd0;
            lat_w    <= 1'b0;
            lat_addr <= 32'h0;
            lat_data <= 32'h0;
            led_out  <= 16'h0;
            cnt_q    <= 32'h0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
            if (latch_en) begin
                lat_w    <= mem_w;
                lat_addr <= addr_bus;
                lat_data <= Cpu_data2bus;
            end
            if (do_wr && sel_led) led_out <= lat_data[15:0];
            if (do_wr && sel_cnt) cnt_q <= lat_data;
            else                  cnt_q <= cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_wr && sel_ram) ram[ram_idx] <= lat_data;
    end

endmodule
